// File: rtl/bp_cce_hybrid_cmd_merge_pkg.sv
// Shared constants and types for the hybrid CCE LCE command merge block.
// Holds FSM state encodings, beat-count width and the BedRock command header sizing.
package bp_cce_hybrid_cmd_merge_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int dword_width_gp              = 64;
    localparam int lce_cmd_msg_header_width_gp = 48;
    localparam int beat_cnt_width_gp           = 4;

    localparam logic [0:0] e_ready = 1'b0;
    localparam logic [0:0] e_data  = 1'b1;

    localparam logic e_src_cached   = 1'b0;
    localparam logic e_src_uncached = 1'b1;

    typedef struct packed {
        logic                                   has_data;
        logic [lce_cmd_msg_header_width_gp-1:0] header;
    } cmd_entry_s;

    function automatic int cce_block_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 512;
            default:          return 512;
        endcase
    endfunction

endpackage

// File: rtl/bp_cce_hybrid_cmd_merge_fifo.sv
// Two-entry header buffer with valid/ready on input and valid/yumi on output.
// No bypass: data enqueued this cycle becomes visible on the following cycle.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mem_d [2];
    logic               rptr_q, rptr_d;
    logic               wptr_q, wptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               enq, deq;

    assign ready_o = (cnt_q != 2'd2);
    assign v_o     = (cnt_q != 2'd0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q ^ enq;
        rptr_d = rptr_q ^ deq;
        cnt_d  = cnt_q;
        if (enq) begin
            mem_d[wptr_q] = data_i;
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rptr_q   <= 1'b0;
            wptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bp_cce_hybrid_cmd_merge.sv
// Merges cached and uncached LCE command bursts onto one output port.
// Headers are round-robin arbitrated and buffered; data beats stream from the locked source.
module bp_cce_hybrid_cmd_merge
    import bp_cce_hybrid_cmd_merge_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int         lce_data_width_p = dword_width_gp,
    localparam int        lce_cmd_msg_header_width_lp = lce_cmd_msg_header_width_gp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    output logic                                   empty_o,

    input  logic [lce_cmd_msg_header_width_lp-1:0] lce_cmd_header_i,
    input  logic                                   lce_cmd_header_v_i,
    output logic                                   lce_cmd_header_ready_and_o,
    input  logic                                   lce_cmd_has_data_i,
    input  logic [lce_data_width_p-1:0]            lce_cmd_data_i,
    input  logic                                   lce_cmd_data_v_i,
    output logic                                   lce_cmd_data_ready_and_o,
    input  logic                                   lce_cmd_last_i,

    input  logic [lce_cmd_msg_header_width_lp-1:0] uc_lce_cmd_header_i,
    input  logic                                   uc_lce_cmd_header_v_i,
    output logic                                   uc_lce_cmd_header_ready_and_o,
    input  logic                                   uc_lce_cmd_has_data_i,
    input  logic [lce_data_width_p-1:0]            uc_lce_cmd_data_i,
    input  logic                                   uc_lce_cmd_data_v_i,
    output logic                                   uc_lce_cmd_data_ready_and_o,
    input  logic                                   uc_lce_cmd_last_i,

    output logic [lce_cmd_msg_header_width_lp-1:0] lce_cmd_header_o,
    output logic                                   lce_cmd_header_v_o,
    input  logic                                   lce_cmd_header_ready_and_i,
    output logic                                   lce_cmd_has_data_o,
    output logic [lce_data_width_p-1:0]            lce_cmd_data_o,
    output logic                                   lce_cmd_data_v_o,
    input  logic                                   lce_cmd_data_ready_and_i,
    output logic                                   lce_cmd_last_o
);

    localparam int max_beats_lp = cce_block_width(bp_params_p) / lce_data_width_p;

    logic [0:0]                   state_q, state_d;
    logic                         prio_q, prio_d;
    logic                         lock_q, lock_d;
    logic [beat_cnt_width_gp-1:0] beat_cnt_q, beat_cnt_d;

    cmd_entry_s enq_entry, deq_entry;
    logic       fifo_ready, fifo_v, fifo_yumi;
    logic       grant_c, grant_uc, hdr_accept, in_data, data_hs;

    // Both valid: the priority source wins; otherwise the lone valid source wins.
    always_comb begin
        grant_c  = 1'b0;
        grant_uc = 1'b0;
        if ((state_q == e_ready) && fifo_ready && !reset_i) begin
            if (lce_cmd_header_v_i && (!uc_lce_cmd_header_v_i || (prio_q == e_src_cached))) begin
                grant_c = 1'b1;
            end else if (uc_lce_cmd_header_v_i) begin
                grant_uc = 1'b1;
            end
        end
    end

    assign lce_cmd_header_ready_and_o    = grant_c;
    assign uc_lce_cmd_header_ready_and_o = grant_uc;
    assign hdr_accept                    = grant_c | grant_uc;

    assign enq_entry.has_data = grant_uc ? uc_lce_cmd_has_data_i : lce_cmd_has_data_i;
    assign enq_entry.header   = grant_uc ? uc_lce_cmd_header_i   : lce_cmd_header_i;

    bsg_two_fifo #(
        .width_p ($bits(cmd_entry_s))
    ) header_buffer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (enq_entry),
        .v_i     (hdr_accept),
        .ready_o (fifo_ready),
        .data_o  (deq_entry),
        .v_o     (fifo_v),
        .yumi_i  (fifo_yumi)
    );

    assign fifo_yumi          = fifo_v & lce_cmd_header_ready_and_i;
    assign lce_cmd_header_v_o = fifo_v;
    assign lce_cmd_header_o   = deq_entry.header;
    assign lce_cmd_has_data_o = deq_entry.has_data;
    assign empty_o            = (state_q == e_ready) & ~fifo_v;

    assign in_data          = (state_q == e_data);
    assign lce_cmd_data_o   = lock_q ? uc_lce_cmd_data_i : lce_cmd_data_i;
    assign lce_cmd_data_v_o = in_data & (lock_q ? uc_lce_cmd_data_v_i : lce_cmd_data_v_i);
    assign lce_cmd_last_o   = in_data & (lock_q ? uc_lce_cmd_last_i : lce_cmd_last_i);

    assign lce_cmd_data_ready_and_o    = in_data & (lock_q == e_src_cached)   & lce_cmd_data_ready_and_i;
    assign uc_lce_cmd_data_ready_and_o = in_data & (lock_q == e_src_uncached) & lce_cmd_data_ready_and_i;

    assign data_hs = lce_cmd_data_v_o & lce_cmd_data_ready_and_i;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_d     = lock_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            e_ready: begin
                if (hdr_accept) begin
                    prio_d = grant_c ? e_src_uncached : e_src_cached;
                    if (enq_entry.has_data) begin
                        state_d    = e_data;
                        lock_d     = grant_uc;
                        beat_cnt_d = '0;
                    end
                end
            end
            e_data: begin
                if (data_hs) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + beat_cnt_width_gp'(1);
                    end
                    if (lce_cmd_last_o) begin
                        state_d = e_ready;
                    end
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_ready;
            prio_q     <= e_src_cached;
            lock_q     <= e_src_cached;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // A burst longer than one cache block means a source broke the protocol.
    beat_cnt_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
        int'(beat_cnt_q) <= max_beats_lp);

endmodule
